// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Width of the chunk index counter; never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk.sv
// CHUNK-bit ripple-carry adder slice, reused once per clock by the multicycle adder.
// Latency: purely combinational.
// Backpressure: none; the caller sequences chunks through it.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    // Ripple the carry bit by bit; c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[CHUNK];
        c_msb = c[CHUNK - 1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract of two WIDTH-bit operands, CHUNK bits per clock through one shared slice.
// Latency: done pulses NCHUNK edges after the edge that accepts start.
// Backpressure: start is only accepted in IDLE or DONE; requests while BUSY are dropped.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = idx_width(NCHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK-1:0] s_chk;
    logic             chk_cout;
    logic             chk_cmsb;
    logic             accept;
    logic             last_chunk;

    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    // Select the operand chunk addressed by the index counter.
    always_comb begin
        a_chk = '0;
        b_chk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                a_chk = a_q[i*CHUNK +: CHUNK];
                b_chk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_chk),
        .b     (b_chk),
        .cin   (carry_q),
        .sum   (s_chk),
        .cout  (chk_cout),
        .c_msb (chk_cmsb)
    );

    // State and datapath registers; clr wins over everything and drops any in-flight op.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on start, BUSY -> DONE after the last chunk,
    // DONE -> BUSY again if start is already waiting, otherwise back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)      state_d = ST_BUSY;
            ST_BUSY: if (last_chunk) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept (subtract folds into ~b and an inverted
    // carry-in), then write one result chunk per BUSY cycle. Unwritten chunks of sum
    // keep their previous value; cout/ovf only change on the final chunk.
    always_comb begin
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin ^ sub;
            k_d     = '0;
        end else if (state_q == ST_BUSY) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (k_q == KW'(i)) begin
                    sum_d[i*CHUNK +: CHUNK] = s_chk;
                end
            end
            carry_d = chk_cout;
            k_d     = last_chunk ? '0 : k_q + KW'(1);
            if (last_chunk) begin
                cout_d = chk_cout;
                ovf_d  = chk_cmsb ^ chk_cout;
            end
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (state_q == ST_BUSY);
        done = (state_q == ST_DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
